// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared MemOp codes, FSM states and beat-count helper
package mips_mem_defs;

  localparam logic [2:0] MEMOP_BYTE = 3'b001;
  localparam logic [2:0] MEMOP_HALF = 3'b010;
  localparam logic [2:0] MEMOP_WORD = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_TAIL = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Zero marks an illegal size code.
  function automatic logic [2:0] beat_count(input logic [2:0] mem_op);
    case (mem_op)
      MEMOP_BYTE: beat_count = 3'd1;
      MEMOP_HALF: beat_count = 3'd2;
      MEMOP_WORD: beat_count = 3'd4;
      default:    beat_count = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// rtl/mem_access_unit_load_extender.sv - sign/zero extension of assembled load bytes
module load_extender
  import mips_mem_defs::*;
(
  input  logic [2:0]  mem_op_i,
  input  logic        sign_i,
  input  logic [31:0] bytes_i,
  output logic [31:0] rdata_o
);

  always_comb begin
    rdata_o = bytes_i;
    case (mem_op_i)
      MEMOP_BYTE: rdata_o = {{24{sign_i & bytes_i[7]}}, bytes_i[7:0]};
      MEMOP_HALF: rdata_o = {{16{sign_i & bytes_i[15]}}, bytes_i[15:0]};
      default:    rdata_o = bytes_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - serialises byte/half/word loads and stores onto a byte-wide RAM
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [2:0]        MemOp,
  input  logic              MemWrite,
  input  logic              MemtoRegSign,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  import mips_mem_defs::*;

  state_t            state_q;
  logic [2:0]        op_q;
  logic              we_q;
  logic              sign_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [1:0]        beat_q;
  logic [2:0]        nbeat_q;
  logic [31:0]       cap_q;
  logic [31:0]       cap_d;
  logic              busy_q, done_q, err_q, mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic [31:0]       rdata_q;

  logic [2:0]  req_n;
  logic        req_bad;
  logic        last_beat;
  logic [1:0]  beat_nx;
  logic        cap_en;
  logic [1:0]  cap_idx;
  logic [31:0] ext_rdata;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W];

  assign req_n   = beat_count(MemOp);
  assign req_bad = (req_n == 3'd0)
                 | ((MemOp == MEMOP_HALF) & addr[0])
                 | ((MemOp == MEMOP_WORD) & (addr[1:0] != 2'b00));

  assign last_beat = ({1'b0, beat_q} == (nbeat_q - 3'd1));
  assign beat_nx   = beat_q + 2'd1;

  // RAM data lags its beat by one cycle: byte i-1 arrives while beat i is on the bus.
  assign cap_en  = !we_q && (((state_q == ST_XFER) && (beat_q != 2'd0)) || (state_q == ST_TAIL));
  assign cap_idx = (state_q == ST_TAIL) ? (nbeat_q[1:0] - 2'd1) : (beat_q - 2'd1);

  always_comb begin
    cap_d = cap_q;
    if (cap_en) cap_d[{cap_idx, 3'b000} +: 8] = mem_rdata;
  end

  load_extender u_ext (
    .mem_op_i (op_q),
    .sign_i   (sign_q),
    .bytes_i  (cap_d),
    .rdata_o  (ext_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      we_q        <= 1'b0;
      sign_q      <= 1'b0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      beat_q      <= 2'd0;
      nbeat_q     <= 3'd0;
      cap_q       <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      rdata_q     <= 32'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= MemOp;
            we_q    <= MemWrite;
            sign_q  <= MemtoRegSign;
            base_q  <= addr[ADDR_W-1:0];
            wdata_q <= wdata;
            nbeat_q <= req_n;
            beat_q  <= 2'd0;
            cap_q   <= 32'd0;
            busy_q  <= 1'b1;
            if (req_bad) begin
              state_q <= ST_RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q     <= ST_XFER;
              mem_en_q    <= 1'b1;
              mem_we_q    <= MemWrite;
              mem_addr_q  <= addr[ADDR_W-1:0];
              mem_wdata_q <= wdata[7:0];
            end
          end
        end
        ST_XFER: begin
          cap_q <= cap_d;
          if (last_beat) begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (we_q) begin
              state_q <= ST_RESP;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_TAIL;
            end
          end else begin
            beat_q      <= beat_nx;
            mem_addr_q  <= base_q + ADDR_W'(beat_nx);
            mem_wdata_q <= wdata_q[{beat_nx, 3'b000} +: 8];
          end
        end
        ST_TAIL: begin
          cap_q   <= cap_d;
          rdata_q <= ext_rdata;
          state_q <= ST_RESP;
          done_q  <= 1'b1;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed table-driven bench for mem_access_unit
module tb_mem_access_unit;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic [2:0]        MemOp = 3'd0;
  logic              MemWrite = 1'b0;
  logic              MemtoRegSign = 1'b0;
  logic [31:0]       addr = 32'd0;
  logic [31:0]       wdata = 32'd0;
  logic              busy, done, err;
  logic [31:0]       rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'd0;

  logic [7:0] ram [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic        we;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [17];

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .MemOp        (MemOp),
    .MemWrite     (MemWrite),
    .MemtoRegSign (MemtoRegSign),
    .addr         (addr),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rdata        (rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, en_cnt, beat_bad, busy_bad, nb;
    logic got, err_seen;
    logic [ADDR_W-1:0] ea;
    nb = (v.op == 3'b001) ? 1 : (v.op == 3'b010) ? 2 : (v.op == 3'b100) ? 4 : 0;
    @(negedge clk);
    MemOp = v.op; MemWrite = v.we; MemtoRegSign = v.sgn; addr = v.addr; wdata = v.wd;
    req_valid = 1'b1;
    @(posedge clk);
    lat = 0; got = 1'b0; en_cnt = 0; beat_bad = 0; busy_bad = 0; err_seen = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_we && !mem_en) beat_bad++;
      if (mem_en) begin
        ea = v.addr[ADDR_W-1:0] + en_cnt[ADDR_W-1:0];
        if (en_cnt > 3 || mem_addr !== ea || mem_we !== v.we ||
            (v.we && mem_wdata !== v.wd[8*en_cnt +: 8])) beat_bad++;
        en_cnt++;
      end
      if (done) begin
        got = 1'b1;
        err_seen = err;
      end else begin
        if (!busy) busy_bad++;
        if (err) beat_bad++;
      end
    end
    req_valid = 1'b0;
    chk({tag, "_latency"}, lat, v.exp_lat);
    chk({tag, "_err"}, {31'd0, err_seen}, {31'd0, v.exp_err});
    chk({tag, "_rdata"}, rdata, v.exp_rd);
    chk({tag, "_beats"}, en_cnt, v.exp_err ? 0 : nb);
    chk({tag, "_beat_bad"}, beat_bad, 0);
    chk({tag, "_busy"}, busy_bad, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {29'd0, done, err, busy}, 32'd0);
  endtask

  initial begin
    int lat, beats, nd;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
    ram[10'h11] = 8'h80;
    ram[10'h12] = 8'h34;
    ram[10'h13] = 8'h92;

    vecs[0]  = '{3'b001, 1'b0, 1'b1, 32'h11,  32'h0,        32'hFFFFFF80, 1'b0, 3};
    vecs[1]  = '{3'b001, 1'b0, 1'b0, 32'h11,  32'h0,        32'h00000080, 1'b0, 3};
    vecs[2]  = '{3'b010, 1'b0, 1'b1, 32'h12,  32'h0,        32'hFFFF9234, 1'b0, 4};
    vecs[3]  = '{3'b010, 1'b0, 1'b0, 32'h12,  32'h0,        32'h00009234, 1'b0, 4};
    vecs[4]  = '{3'b100, 1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h00009234, 1'b0, 5};
    vecs[5]  = '{3'b100, 1'b0, 1'b1, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 6};
    vecs[6]  = '{3'b010, 1'b0, 1'b1, 32'h13,  32'h0,        32'hDEADBEEF, 1'b1, 1};
    vecs[7]  = '{3'b100, 1'b1, 1'b0, 32'h0E,  32'h11223344, 32'hDEADBEEF, 1'b1, 1};
    vecs[8]  = '{3'b011, 1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b1, 1};
    vecs[9]  = '{3'b001, 1'b0, 1'b1, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0, 3};
    vecs[10] = '{3'b010, 1'b0, 1'b1, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0, 4};
    vecs[11] = '{3'b010, 1'b1, 1'b0, 32'h20,  32'h1234ABCD, 32'hFFFFDEAD, 1'b0, 3};
    vecs[12] = '{3'b010, 1'b0, 1'b0, 32'h20,  32'h0,        32'h0000ABCD, 1'b0, 4};
    vecs[13] = '{3'b001, 1'b1, 1'b0, 32'h3FF, 32'h00000055, 32'h0000ABCD, 1'b0, 2};
    vecs[14] = '{3'b001, 1'b0, 1'b1, 32'h7FF, 32'h0,        32'h00000055, 1'b0, 3};
    vecs[15] = '{3'b000, 1'b0, 1'b0, 32'h40,  32'h0,        32'h00000055, 1'b1, 1};
    vecs[16] = '{3'b100, 1'b0, 1'b0, 32'h21,  32'h0,        32'h00000055, 1'b1, 1};

    #1 reset = 1'b1;
    #2;
    chk("reset_ctrl", {27'd0, busy, done, err, mem_en, mem_we}, 32'd0);
    chk("reset_bus", {14'd0, mem_addr, mem_wdata}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Held SB followed back-to-back by LBU at the same address
    @(negedge clk);
    MemOp = 3'b001; MemWrite = 1'b1; MemtoRegSign = 1'b0; addr = 32'h30; wdata = 32'h000000A7;
    req_valid = 1'b1;
    @(posedge clk);
    lat = 0; beats = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_en) beats++;
      if (done) break;
    end
    chk("b2b_sb_latency", lat, 2);
    chk("b2b_sb_beats", beats, 1);
    MemWrite = 1'b0;
    @(negedge clk);
    chk("b2b_idle_gap", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("b2b_accept", {19'd0, busy, mem_en, mem_we, mem_addr}, {19'd0, 1'b1, 1'b1, 1'b0, 10'h030});
    req_valid = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_lbu_latency", lat, 3);
    chk("b2b_lbu_rdata", rdata, 32'h000000A7);

    // Reset in cycle 2 of a SW
    repeat (2) @(negedge clk);
    MemOp = 3'b100; MemWrite = 1'b1; addr = 32'h40; wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_sw_beat0", {21'd0, mem_en, mem_addr}, {21'd0, 1'b1, 10'h040});
    @(posedge clk);
    #1 reset = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rst_async_ctrl", {27'd0, busy, done, err, mem_en, mem_we}, 32'd0);
    chk("rst_async_bus", {14'd0, mem_addr, mem_wdata}, 32'd0);
    chk("rst_async_rdata", rdata, 32'd0);
    nd = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) nd++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || mem_en) nd++;
    end
    chk("rst_no_done", nd, 0);
    chk("rst_ram_b0", {24'd0, ram[10'h40]}, 32'h0000000D);
    chk("rst_ram_b1", {8'd0, ram[10'h43], ram[10'h42], ram[10'h41]}, 32'd0);
    run_vec('{3'b100, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0000000D, 1'b0, 6}, "post_rst_lw");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
